// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stream source.
//   LFSR_MAX_BITS : widest supported LFSR.
//   state_e       : stream FSM states (idle / seed-load flush / running).
//   lfsr_taps()   : maximal-length XNOR tap mask for a given width; bit n set means
//                   register bit n (1-based tap position n+1) feeds the XNOR.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_BITS = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    function automatic logic [LFSR_MAX_BITS-1:0] lfsr_taps(input int unsigned width);
        logic [LFSR_MAX_BITS-1:0] mask;
        case (width)
            3:       mask = 32'h0000_0006;
            4:       mask = 32'h0000_000C;
            5:       mask = 32'h0000_0014;
            6:       mask = 32'h0000_0030;
            7:       mask = 32'h0000_0060;
            8:       mask = 32'h0000_00B8;
            9:       mask = 32'h0000_0110;
            10:      mask = 32'h0000_0240;
            11:      mask = 32'h0000_0500;
            12:      mask = 32'h0000_0829;
            13:      mask = 32'h0000_100D;
            14:      mask = 32'h0000_2015;
            15:      mask = 32'h0000_6000;
            16:      mask = 32'h0000_D008;
            17:      mask = 32'h0001_2000;
            18:      mask = 32'h0002_0400;
            19:      mask = 32'h0004_0023;
            20:      mask = 32'h0009_0000;
            21:      mask = 32'h0014_0000;
            22:      mask = 32'h0030_0000;
            23:      mask = 32'h0042_0000;
            24:      mask = 32'h00E1_0000;
            25:      mask = 32'h0120_0000;
            26:      mask = 32'h0200_0023;
            27:      mask = 32'h0400_0013;
            28:      mask = 32'h0900_0000;
            29:      mask = 32'h1400_0000;
            30:      mask = 32'h2000_0029;
            31:      mask = 32'h4800_0000;
            32:      mask = 32'h8020_0003;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_step_comb.sv
// Combinational multi-step LFSR advance.
//   r_i   : current LFSR word.
//   adv_o : r_i shifted STEP times through the XNOR single-step function.
// Each step shifts left and inserts the XNOR of the tap bits at bit 0. All tap sets
// have an even tap count, so the reduction XNOR equals a chained XNOR.
module lfsr_step_comb #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned STEP     = 1
) (
    input  logic [NUM_BITS-1:0] r_i,
    output logic [NUM_BITS-1:0] adv_o
);
    import lfsr_pkg::*;

    localparam logic [NUM_BITS-1:0] TapMask = NUM_BITS'(lfsr_taps(NUM_BITS));

    logic [NUM_BITS-1:0] stage [0:STEP];

    assign stage[0] = r_i;

    for (genvar i = 0; i < int'(STEP); i++) begin : gen_step
        assign stage[i+1] = {stage[i][NUM_BITS-2:0], ~^(stage[i] & TapMask)};
    end

    assign adv_o = stage[STEP];

endmodule

// File: rtl/lfsr_stream.sv
// XNOR-feedback LFSR pattern source with a valid/ready output stream.
//   i_Clk, i_Rst          : clock, asynchronous active-high reset.
//   i_Enable              : run request.
//   i_Seed_DV/i_Seed_Data : seed-load strobe and value; flushes the current word.
//   o_Data/o_Valid/i_Ready: output word stream; a word is consumed on o_Valid && i_Ready.
//   o_Done                : one-cycle pulse when the sequence returns to its start value.
//   o_Lockup              : sticky until the next seed; the last seed was all-ones.
module lfsr_stream #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned STEP     = 1
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic [NUM_BITS-1:0] o_Data,
    output logic                o_Valid,
    input  logic                i_Ready,
    output logic                o_Done,
    output logic                o_Lockup
);
    import lfsr_pkg::*;

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] r_q, r_d;
    logic [NUM_BITS-1:0] start_q, start_d;
    logic                done_q, done_d;
    logic                lockup_q, lockup_d;

    logic [NUM_BITS-1:0] r_adv;
    logic                accept;
    logic                seed_lock;

    lfsr_step_comb #(
        .NUM_BITS (NUM_BITS),
        .STEP     (STEP)
    ) u_step (
        .r_i   (r_q),
        .adv_o (r_adv)
    );

    // Valid is exactly "in RUN", so the handshake only needs the state.
    assign accept    = (state_q == StRun) && i_Ready;
    // All-ones is the XNOR lock-up state; such a seed is replaced by zero.
    assign seed_lock = (i_Seed_Data == {NUM_BITS{1'b1}});

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= StIdle;
            r_q      <= '0;
            start_q  <= '0;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            start_q  <= start_d;
            done_q   <= done_d;
            lockup_q <= lockup_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        start_d  = start_q;
        done_d   = 1'b0;
        lockup_d = lockup_q;

        if (i_Seed_DV) begin
            // Seed beats a simultaneous accept: the current word is dropped, not advanced.
            state_d  = StLoad;
            r_d      = seed_lock ? '0 : i_Seed_Data;
            start_d  = seed_lock ? '0 : i_Seed_Data;
            lockup_d = seed_lock;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_Enable) begin
                        state_d = StRun;
                    end
                end
                StLoad: begin
                    state_d = i_Enable ? StRun : StIdle;
                end
                StRun: begin
                    if (accept) begin
                        r_d    = r_adv;
                        done_d = (r_adv == start_q);
                        if (!i_Enable) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_Data   = r_q;
        o_Valid  = (state_q == StRun);
        o_Done   = done_q;
        o_Lockup = lockup_q;
    end

    param_range_a : assert property (@(posedge i_Clk)
        (NUM_BITS >= 3) && (NUM_BITS <= LFSR_MAX_BITS) && (STEP >= 1) && (STEP <= NUM_BITS));

    no_lockup_a : assert property (@(posedge i_Clk) disable iff (i_Rst)
        r_q != {NUM_BITS{1'b1}});

    valid_stable_a : assert property (@(posedge i_Clk) disable iff (i_Rst)
        (o_Valid && !i_Ready && !i_Seed_DV) |=> (o_Valid && $stable(o_Data)));

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
- Parametrised XNOR-feedback LFSR pattern source with a valid/ready output stream. It serves test-pattern generators, scramblers and BIST sources that must not drop words under backpressure.
- Advances STEP single-bit shifts per accepted word.
- Supports seed load with flush, all-ones lock-up protection, and an end-of-sequence pulse.

Parameters:
- NUM_BITS, 8, LFSR width; legal 3..32; uses the maximal-length XNOR tap set for each width.
- STEP, 1, single-bit LFSR shifts applied per accepted word; legal 1..NUM_BITS.

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Enable  in  1  run request.
- i_Seed_DV  in  1  one-cycle seed-load strobe; highest priority after reset.
- i_Seed_Data  in  NUM_BITS  seed value.
- o_Data  out  NUM_BITS  current LFSR word; bit 0 is the feedback insertion bit.
- o_Valid  out  1  o_Data is valid.
- i_Ready  in  1  consumer accepts when o_Valid && i_Ready.
- o_Done  out  1  one-cycle pulse when the sequence returns to its start value.
- o_Lockup  out  1  sticky flag: an all-ones seed was rejected.

Behaviour:
- Single-step function:
  - fb = XNOR of the tap bits for NUM_BITS.
  - next = {r[NUM_BITS-2:0], fb}.
  - Taps, using 1-based positions = bit index + 1:
    - 3:{3,2}, 4:{4,3}, 5:{5,3}, 6:{6,5}, 7:{7,6}, 8:{8,6,5,4}, 9:{9,5}, 10:{10,7}, 11:{11,9}
    - 12:{12,6,4,1}, 13:{13,4,3,1}, 14:{14,5,3,1}, 15:{15,14}, 16:{16,15,13,4}, 17:{17,14}
    - 18:{18,11}, 19:{19,6,2,1}, 20:{20,17}, 21:{21,19}, 22:{22,21}, 23:{23,18}
    - 24:{24,23,22,17}, 25:{25,22}, 26:{26,6,2,1}, 27:{27,5,2,1}, 28:{28,25}, 29:{29,27}
    - 30:{30,6,4,1}, 31:{31,28}, 32:{32,22,2,1}
- Word advance: the step function is applied STEP times combinationally within one cycle.
- Reset (async, i_Rst=1):
  - state=IDLE, r=0, start=0.
  - o_Valid=0, o_Done=0, o_Lockup=0.
  - o_Data=0 (o_Data is always r).
- State machine, IDLE/LOAD/RUN:
  - IDLE: o_Valid=0. Go to RUN when i_Enable=1; the first word (r) is valid on the next cycle.
  - RUN: o_Valid=1.
    - On accept: r <= advance(r).
    - If i_Enable=0 at accept: go to IDLE with r advanced.
    - If i_Enable=0 without accept: stay in RUN holding o_Data stable. Valid never drops without an accept.
  - LOAD: o_Valid=0 for exactly one cycle, then RUN if i_Enable=1, else IDLE.
- Seed load (i_Seed_DV=1, any state):
  - Next state is LOAD and the current word is discarded (flush; the only exception to valid stability).
  - r <= i_Seed_Data and start <= i_Seed_Data.
  - If i_Seed_Data is all-ones (the XNOR lock-up state): r <= 0, start <= 0, o_Lockup <= 1.
  - Otherwise o_Lockup <= 0.
  - Seed and accept in the same cycle: the seed wins and the accept is ignored (no advance).
- o_Done:
  - Registered; pulses the cycle after an accept whose advanced value equals start.
  - Period = (2^NUM_BITS-1)/gcd(STEP, 2^NUM_BITS-1) accepted words.
  - No pulse during LOAD or IDLE.
- i_Enable low in IDLE: r holds. Re-enable resumes the sequence without restart.
- Reset asserted mid-stream: outputs go to reset values immediately and asynchronously.
- Sequence invariant: r never reaches all-ones after reset or a sanitised seed.

Decomposition:
- Shared package lfsr_pkg:
  - state enum {IDLE, LOAD, RUN}.
  - function lfsr_taps(width) returning a 32-bit tap mask.
  - constant LFSR_MAX_BITS=32.
- Sub-module lfsr_step_comb (combinational): params NUM_BITS and STEP; input r, output advance(r).
  - Built as an unrolled STEP-deep loop of the single-step function, reusable by a future checker block.
- Top level holds the FSM, r/start registers, done/lockup flags and parameter range assertions.

Test Plan:
- Free run: NUM_BITS=3, STEP=1, reset, i_Enable=1, i_Ready=1 -> o_Data = 000,001,011,110,101,010,100,000; o_Done pulses once per 7 accepts, on the cycle 000 reappears.
- Backpressure: NUM_BITS=3, i_Ready=0 for 4 cycles while o_Data=011 -> o_Valid stays 1, o_Data stays 011; next accept yields 110; no word skipped or repeated.
- Seed flush: NUM_BITS=8, seed 0xA5 pulsed while RUN with i_Ready=1 -> next cycle o_Valid=0, following cycle o_Valid=1 with o_Data=0xA5; o_Done pulses after 255 accepts.
- Lock-up: NUM_BITS=4, seed 0xF -> o_Lockup=1, o_Data=0x0 after LOAD; then seed 0x3 -> o_Lockup=0, o_Data=0x3.
- Multi-step: NUM_BITS=3, STEP=2, from reset -> o_Data = 000,011,101,100,001,110,010,000; o_Done every 7 accepts.
- Reset mid-stream: i_Rst=1 asynchronously while o_Valid=1 and i_Ready=0 -> o_Valid=0, o_Data=0 before the next clock edge; o_Lockup cleared.
